// File: rtl/bsram_arb_pkg.sv
// Shared constants for the block-RAM arbiter: state encoding,
// default RAM geometry and requester port ids.
package bsram_arb_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: a lone request wins outright,
// contention goes to the port that was not granted last.
module rr_arb2
    import bsram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Pure combinational choice; the caller owns last_grant.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = PORT0;
        if (req == 2'b11)
            gnt_id = ~last_grant;
        else if (req[1])
            gnt_id = PORT1;
    end

endmodule

// File: rtl/bsram_arbiter.sv
// Shares one single-port block RAM between the I2C register side
// (port 0) and a fabric master (port 1) with round-robin arbitration.
module bsram_arbiter
    import bsram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    localparam logic [2:0] LAT = 3'(READ_LAT);

    logic [1:0]        state;
    logic              last_grant;
    logic              cmd_id;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [2:0]        cnt;
    logic              gnt_valid;
    logic              gnt_id;
    logic              capture;

    rr_arb2 u_pick (
        .req        ({r1_req, r0_req}),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // RAM pins and acks decode straight from state, so an async reset
    // drops them (mem_wre included) without waiting for a clock.
    always_comb begin
        busy     = (state != ST_IDLE);
        mem_ce   = (state == ST_ISSUE) || (state == ST_WAIT);
        mem_wre  = (state == ST_ISSUE) && cmd_we;
        mem_addr = busy ? cmd_addr : '0;
        mem_din  = busy ? cmd_wdata : '0;
        r0_ack   = (state == ST_ACK) && (cmd_id == PORT0);
        r1_ack   = (state == ST_ACK) && (cmd_id == PORT1);
        capture  = (state == ST_WAIT) && (cnt == 3'd1);
    end

    // Access sequencer: latch the winner's command, issue, wait, ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= PORT1;
            cmd_id     <= PORT0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cnt        <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        cmd_id    <= gnt_id;
                        cmd_we    <= gnt_id ? r1_we    : r0_we;
                        cmd_addr  <= gnt_id ? r1_addr  : r0_addr;
                        cmd_wdata <= gnt_id ? r1_wdata : r0_wdata;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_we) begin
                        state <= ST_ACK;
                    end else begin
                        cnt   <= LAT;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1)
                        state <= ST_ACK;
                end
                ST_ACK: begin
                    last_grant <= cmd_id;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read data lands only in the granted port's register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_rdata <= '0;
            r1_rdata <= '0;
        end else if (capture) begin
            if (cmd_id == PORT1)
                r1_rdata <= mem_dout;
            else
                r0_rdata <= mem_dout;
        end
    end

endmodule

// File: tb/tb_bsram_arbiter.sv
// Bench for bsram_arbiter: a behavioural RAM, directed accesses and a
// scoreboard of expected acks checked by an independent monitor.
module tb_bsram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
    logic [13:0] r0_addr = 0, r1_addr = 0;
    logic [7:0]  r0_wdata = 0, r1_wdata = 0;
    logic        r0_ack, r1_ack, mem_ce, mem_wre, busy;
    logic [7:0]  r0_rdata, r1_rdata, mem_din;
    logic [7:0]  mem_dout = 0;
    logic [13:0] mem_addr;

    logic        q0_req = 0;
    logic        q0_ack, q1_ack, q_ce, q_wre, q_busy;
    logic [7:0]  q0_rdata, q1_rdata, q_din;
    logic [13:0] q_addr;
    logic [7:0]  cnt3 = 0;

    logic [7:0]  ram [0:16383];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic       port;
        logic       rd;
        logic [7:0] rdata;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_wre) ram[mem_addr] <= mem_din;
            else mem_dout <= ram[mem_addr];
        end
    end

    always @(posedge clk) cnt3 <= cnt3 + 8'd1;

    bsram_arbiter #(.READ_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .mem_ce(mem_ce), .mem_wre(mem_wre), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
    );

    bsram_arbiter #(.READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .r0_req(q0_req), .r0_we(1'b0), .r0_addr(14'h0005),
        .r0_wdata(8'h00), .r0_ack(q0_ack), .r0_rdata(q0_rdata),
        .r1_req(1'b0), .r1_we(1'b0), .r1_addr(14'h0000),
        .r1_wdata(8'h00), .r1_ack(q1_ack), .r1_rdata(q1_rdata),
        .mem_ce(q_ce), .mem_wre(q_wre), .mem_addr(q_addr),
        .mem_din(q_din), .mem_dout(cnt3), .busy(q_busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops the oldest expectation and is checked.
    always @(negedge clk) begin
        if (r0_ack || r1_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, r1_ack, r0_ack}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_port", {30'd0, r1_ack, r0_ack},
                    e.port ? 32'd2 : 32'd1);
                chk("ack_cycle", cyc, e.cyc);
                if (e.rd)
                    chk("rdata", e.port ? r1_rdata : r0_rdata, e.rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [13:0] addr, input logic [7:0] wd);
        if (port) begin
            r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wd;
        end else begin
            r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wd;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // One uncontended access; the write pulse is counted on the RAM pins.
    task automatic do_access(input logic port, input logic we,
                             input logic [13:0] addr, input logic [7:0] wd,
                             input logic [7:0] exp_rd);
        int          c, n, wcnt;
        logic [13:0] wa;
        logic [7:0]  wdv;
        c = cyc;
        n = we ? 3 : 4;
        wcnt = 0; wa = 0; wdv = 0;
        sb.push_back('{port, !we, exp_rd, c + n - 1});
        drive(port, 1'b1, we, addr, wd);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (mem_wre) begin
                wcnt++;
                wa = mem_addr;
                wdv = mem_din;
            end
            tick();
        end
        drive(port, 1'b0, 1'b0, 14'h0, 8'h0);
        @(negedge clk);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("wre_pulses", wcnt, {31'd0, we});
        if (we) begin
            chk("wr_addr", {18'd0, wa}, {18'd0, addr});
            chk("wr_data", {24'd0, wdv}, {24'd0, wd});
        end
        tick();
    endtask

    initial begin
        int         c;
        int         got;
        logic [7:0] v0, rd3;

        #2;
        chk("rst_ack", {30'd0, r1_ack, r0_ack}, 32'd0);
        chk("rst_mem", {29'd0, mem_ce, mem_wre, busy}, 32'd0);
        chk("rst_bus", {4'd0, mem_addr, mem_din}, 32'd0);
        chk("rst_rdata", {16'd0, r1_rdata, r0_rdata}, 32'd0);
        do_reset();

        do_access(1'b0, 1'b1, 14'h0123, 8'hA5, 8'h00);
        do_access(1'b1, 1'b0, 14'h0123, 8'h00, 8'hA5);
        chk("r0_rdata_kept", {24'd0, r0_rdata}, 32'd0);

        do_reset();
        c = cyc;
        sb.push_back('{1'b0, 1'b0, 8'h00, c + 2});
        sb.push_back('{1'b1, 1'b0, 8'h00, c + 5});
        sb.push_back('{1'b0, 1'b0, 8'h00, c + 8});
        sb.push_back('{1'b1, 1'b0, 8'h00, c + 11});
        drive(1'b0, 1'b1, 1'b1, 14'h0000, 8'h11);
        drive(1'b1, 1'b1, 1'b1, 14'h0200, 8'h77);
        while (cyc < c + 12) begin
            @(negedge clk);
            if (cyc == c + 3 || cyc == c + 6 || cyc == c + 9)
                chk("busy_gap", {31'd0, busy}, 32'd0);
            tick();
            if (cyc == c + 9) r0_req = 1'b0;
        end
        r1_req = 1'b0;
        tick();

        do_access(1'b0, 1'b1, 14'h3FFF, 8'h5A, 8'h00);
        do_access(1'b1, 1'b0, 14'h3FFF, 8'h00, 8'h5A);
        do_access(1'b1, 1'b0, 14'h0000, 8'h00, 8'h11);
        do_access(1'b0, 1'b0, 14'h0200, 8'h00, 8'h77);

        drive(1'b0, 1'b1, 1'b0, 14'h3FFF, 8'h00);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_mem", {29'd0, mem_ce, mem_wre, busy}, 32'd0);
        chk("mid_rst_ack", {30'd0, r1_ack, r0_ack}, 32'd0);
        chk("mid_rst_rdata", {16'd0, r1_rdata, r0_rdata}, 32'd0);
        chk("mid_rst_addr", {18'd0, mem_addr}, 32'd0);
        r0_req = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        do_access(1'b0, 1'b0, 14'h3FFF, 8'h00, 8'h5A);

        c = cyc;
        v0 = cnt3;
        got = -1;
        rd3 = 8'h00;
        q0_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (q0_ack) begin
                got = cyc;
                rd3 = q0_rdata;
                break;
            end
            tick();
        end
        tick();
        q0_req = 1'b0;
        chk("lat3_cycle", got, c + 5);
        chk("lat3_rdata", {24'd0, rd3}, {24'd0, 8'(v0 + 8'd4)});

        for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bsram_arbiter.md
Name: bsram_arbiter

Overview:
- Shares the single-port block RAM (14-bit address, 8-bit data, registered read output) between two requesters.
- Port 0 is the I2C register-interface side; port 1 is a local/fabric master.
- Round-robin arbitration; each granted access is sequenced through a small state machine.
- Every access completes with a one-cycle acknowledge pulse.
- Sits between the requesters and the bsram instance and is the only driver of the RAM control pins.

Parameters:
- ADDR_W, 14, RAM address width.
- DATA_W, 8, RAM data width.
- READ_LAT, 1, number of clock edges from address capture to valid mem_dout (legal range 1..4).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- r0_req  in  1  port 0 request; held high until r0_ack
- r0_we  in  1  port 0 write (1) / read (0); stable while r0_req
- r0_addr  in  ADDR_W  port 0 address; stable while r0_req
- r0_wdata  in  DATA_W  port 0 write data; stable while r0_req
- r0_ack  out  1  one-cycle completion pulse to port 0
- r0_rdata  out  DATA_W  port 0 read data; valid when r0_ack=1
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata: same as port 0, for port 1
- mem_ce  out  1  RAM clock enable
- mem_wre  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_din  out  DATA_W  RAM write data
- mem_dout  in  DATA_W  RAM read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, last_grant=1, so port 0 wins the first contention.
  - All outputs are 0, including mem_ce, mem_wre, acks and rdata registers.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Sample r0_req and r1_req.
  - If exactly one is high, grant it.
  - If both are high, grant the port that is not last_grant.
  - On a grant, latch we/addr/wdata and the granted port id into command registers, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (1 cycle):
  - mem_ce=1, mem_addr and mem_din from the command registers.
  - mem_wre=1 only if the command is a write.
  - Write goes to ACK; read goes to WAIT with the counter loaded to READ_LAT.
- WAIT:
  - mem_addr held, mem_wre=0, mem_ce=1.
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1, capture mem_dout into the granted port's rdata register at the clock edge, then go to ACK.
- ACK (1 cycle):
  - Granted port's ack=1.
  - last_grant is updated to the granted port.
  - Next state is IDLE.
- Handshake:
  - Requester deasserts req in the cycle after it sees ack; IDLE therefore never regrants the same transaction.
  - A requester that keeps req high after ack issues a new access; under contention the other port is served first.
- Latency from the first IDLE cycle with req high:
  - Write: ack in cycle 3.
  - Read: ack in cycle 3+READ_LAT.
- rdata registers:
  - Hold their last captured value until the next read on that port.
  - The non-granted port's rdata is never modified.
- Write data: mem_din equals the latched wdata in every non-IDLE state.
- Requests during busy: the non-granted port's req is ignored until IDLE; no request is lost as long as the requester holds it.
- Simultaneous events:
  - Both ports requesting in IDLE: round-robin as above.
  - Back-to-back contention alternates 0,1,0,1.
- Reset mid-operation:
  - Transaction aborted immediately, no ack issued, mem_wre forced to 0.
  - A write in ISSUE at the reset edge may or may not land in RAM; software must reissue.
- Changing we/addr/wdata while req is high has no effect after the grant, because the command is latched.

Decomposition:
- Shared package bsram_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2, ST_ACK=2'd3;
  - ADDR_W and DATA_W defaults;
  - port id constants.
- One sub-module, rr_arb2: purely the two-requester round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt_valid, gnt_id.
  - Instantiated once; FSM, command registers and rdata capture stay in bsram_arbiter.

Test Plan:
- Reset, then r0 write addr=0x0123 data=0xA5 → mem_wre=1 for exactly one cycle with mem_addr=0x0123, mem_din=0xA5; r0_ack in cycle 3; r1_ack stays 0.
- r1 read addr=0x0123 after that write (READ_LAT=1) → r1_ack in cycle 4, r1_rdata=0xA5; r0_rdata unchanged.
- r0 and r1 request in the same cycle right after reset, both persistent → grants in order 0,1,0,1; each ack is a single-cycle pulse; busy drops between grants.
- Write 0x3FFF=0x5A, then read 0x3FFF and 0x0000 (0x0000 previously written 0x11) → rdata 0x5A then 0x11; top address is not aliased.
- Assert rst during WAIT of an r0 read → all outputs go 0 asynchronously, no r0_ack ever pulses, state returns to IDLE; a new r0 read after release completes normally.
- READ_LAT=3 build: read → ack in cycle 6; captured rdata matches mem_dout at the third edge after ISSUE.
